// File: rtl/image_rom_arbiter.sv
// Two-requester arbiter in front of a synchronous single-port image ROM.
// Display has priority; aux is forced through after MAX_WAIT consecutive denials.
module image_rom_arbiter #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned MAX_WAIT   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_data,
    input  logic                  aux_req,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    output logic                  aux_gnt,
    output logic                  aux_valid,
    output logic [DATA_WIDTH-1:0] aux_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_AUX  = 2'd2
    } tag_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;
    tag_t       tag1;
    tag_t       tag2;
    logic       aux_win;

    // Grants are combinational so a request can be accepted in the cycle it rises.
    always_comb begin
        aux_win  = aux_req && (!disp_req || (wait_cnt == MAX_WAIT_C));
        aux_gnt  = !reset && aux_win;
        disp_gnt = !reset && disp_req && !aux_win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            rom_addr <= '0;
            tag1     <= TAG_NONE;
            tag2     <= TAG_NONE;
        end else begin
            if (aux_gnt)
                wait_cnt <= '0;
            else if (aux_req && (wait_cnt < MAX_WAIT_C))
                wait_cnt <= wait_cnt + 8'd1;

            if (aux_gnt) begin
                rom_addr <= aux_addr;
                tag1     <= TAG_AUX;
            end else if (disp_gnt) begin
                rom_addr <= disp_addr;
                tag1     <= TAG_DISP;
            end else begin
                tag1     <= TAG_NONE;
            end

            tag2 <= tag1;
        end
    end

    // The ROM word lands two cycles after the grant, aligned with tag2.
    always_comb begin
        disp_valid = !reset && (tag2 == TAG_DISP);
        aux_valid  = !reset && (tag2 == TAG_AUX);
        disp_data  = rom_q;
        aux_data   = rom_q;
    end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed and constrained-random checks for image_rom_arbiter with a behavioural ROM.
module tb_image_rom_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 19;
    localparam int unsigned MW = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req, aux_req;
    logic [AW-1:0] disp_addr, aux_addr;
    logic          disp_gnt, disp_valid, aux_gnt, aux_valid;
    logic [DW-1:0] disp_data, aux_data, rom_q;
    logic [AW-1:0] rom_addr;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    image_rom_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .MAX_WAIT  (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_gnt  (disp_gnt),
        .disp_valid(disp_valid),
        .disp_data (disp_data),
        .aux_req   (aux_req),
        .aux_addr  (aux_addr),
        .aux_gnt   (aux_gnt),
        .aux_valid (aux_valid),
        .aux_data  (aux_data),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[7:0] + 8'h5A;
    endfunction

    always @(posedge clk) rom_q <= rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
    endtask

    int unsigned vcount;
    logic [1:0]    p1_tag, p2_tag;
    logic [AW-1:0] p1_addr, p2_addr, exp_rom_addr;
    int unsigned   mwait;
    logic          e_aux, e_disp;

    initial begin
        reset = 1'b1; disp_req = 1'b0; aux_req = 1'b0;
        disp_addr = '0; aux_addr = '0;
        step();
        disp_req = 1'b1;
        at_sample();
        check("reset_disp_gnt", disp_gnt, 0);
        check("reset_aux_gnt", aux_gnt, 0);
        check("reset_disp_valid", disp_valid, 0);
        check("reset_aux_valid", aux_valid, 0);
        check("reset_rom_addr", rom_addr, 0);
        step();

        // Display-only burst of addresses 0,1,2
        reset = 1'b0; disp_addr = 19'd0;
        at_sample(); check("disp_gnt0", disp_gnt, 1);
        step(); disp_addr = 19'd1;
        at_sample(); check("disp_gnt1", disp_gnt, 1); check("rom_addr0", rom_addr, 0);
        step(); disp_addr = 19'd2;
        at_sample(); check("disp_gnt2", disp_gnt, 1); check("rom_addr1", rom_addr, 1);
        check("disp_valid0", disp_valid, 1); check("disp_data0", disp_data, rom_fn(19'd0));
        step(); disp_req = 1'b0;
        at_sample(); check("disp_idle_gnt", disp_gnt, 0); check("rom_addr2", rom_addr, 2);
        check("disp_valid1", disp_valid, 1); check("disp_data1", disp_data, rom_fn(19'd1));
        step();
        at_sample(); check("disp_valid2", disp_valid, 1); check("disp_data2", disp_data, rom_fn(19'd2));
        step();
        at_sample(); check("disp_valid_end", disp_valid, 0);

        // Aux-only access at the top address
        step(); aux_req = 1'b1; aux_addr = 19'h7FFFF;
        at_sample(); check("aux_gnt", aux_gnt, 1); check("aux_disp_gnt", disp_gnt, 0);
        step(); aux_req = 1'b0;
        at_sample(); check("aux_valid_early", aux_valid, 0);
        step();
        at_sample(); check("aux_valid", aux_valid, 1); check("aux_data", aux_data, rom_fn(19'h7FFFF));
        check("aux_disp_valid", disp_valid, 0);
        step();
        at_sample(); check("aux_valid_end", aux_valid, 0);

        // Starvation: both held high, aux forced through on the eighth cycle
        step(); disp_req = 1'b1; aux_req = 1'b1; disp_addr = 19'h10; aux_addr = 19'h20;
        for (int i = 1; i <= 10; i++) begin
            at_sample();
            check($sformatf("starve_disp_gnt%0d", i), disp_gnt, (i == 8) ? 0 : 1);
            check($sformatf("starve_aux_gnt%0d", i), aux_gnt, (i == 8) ? 1 : 0);
            if (i == 10) begin
                check("starve_aux_valid", aux_valid, 1);
                check("starve_aux_data", aux_data, rom_fn(19'h20));
            end
            step();
            if (i == 8) begin
                aux_req = 1'b0;
                check("starve_wait_cleared", dut.wait_cnt, 0);
            end
        end
        disp_req = 1'b0;
        step(); step();

        // Single grant followed by idle cycles
        disp_req = 1'b1; disp_addr = 19'h123;
        at_sample(); check("gap_gnt", disp_gnt, 1);
        step(); disp_req = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            at_sample();
            vcount += (disp_valid ? 1 : 0) + (aux_valid ? 1 : 0);
            step();
        end
        check("gap_valid_count", vcount, 1);
        check("gap_rom_addr_hold", rom_addr, 19'h123);

        // Reset while a read is in flight
        disp_req = 1'b1; disp_addr = 19'h55;
        at_sample(); check("mid_gnt", disp_gnt, 1);
        step(); reset = 1'b1;
        at_sample(); check("mid_rst_disp_gnt", disp_gnt, 0);
        check("mid_rst_valid", disp_valid | aux_valid, 0);
        step(); reset = 1'b0; disp_addr = 19'h9;
        at_sample(); check("mid_no_valid", disp_valid | aux_valid, 0);
        check("mid_rom_addr", rom_addr, 0);
        check("mid_first_gnt", disp_gnt, 1);
        step(); disp_req = 1'b0;
        step();
        at_sample(); check("mid_post_valid", disp_valid, 1); check("mid_post_data", disp_data, rom_fn(19'h9));

        // Random traffic against a reference model of the arbitration rules
        step(); reset = 1'b1; disp_req = 1'b0; aux_req = 1'b0;
        step(); step(); reset = 1'b0;
        mwait = 0; p1_tag = 2'd0; p2_tag = 2'd0; p1_addr = '0; p2_addr = '0; exp_rom_addr = '0;
        for (int c = 0; c < 10000; c++) begin
            at_sample();
            e_aux  = aux_req && (!disp_req || mwait == MW);
            e_disp = disp_req && !e_aux;
            check("rnd_disp_gnt", disp_gnt, e_disp);
            check("rnd_aux_gnt", aux_gnt, e_aux);
            check("rnd_disp_valid", disp_valid, p2_tag == 2'd1);
            check("rnd_aux_valid", aux_valid, p2_tag == 2'd2);
            if (p2_tag != 2'd0) check("rnd_data", rom_q, rom_fn(p2_addr));
            check("rnd_rom_addr", rom_addr, exp_rom_addr);
            check("rnd_wait_bound", dut.wait_cnt <= MW, 1);
            p2_tag = p1_tag; p2_addr = p1_addr;
            if (e_aux) begin
                p1_tag = 2'd2; p1_addr = aux_addr; exp_rom_addr = aux_addr; mwait = 0;
            end else begin
                if (e_disp) begin
                    p1_tag = 2'd1; p1_addr = disp_addr; exp_rom_addr = disp_addr;
                end else begin
                    p1_tag = 2'd0;
                end
                if (aux_req && mwait < MW) mwait++;
            end
            step();
            if (!disp_req || e_disp) begin
                disp_req  = 1'($urandom_range(0, 3) != 0);
                disp_addr = AW'($urandom);
            end
            if (!aux_req || e_aux) begin
                aux_req  = 1'($urandom_range(0, 1));
                aux_addr = AW'($urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
